pc_unit: RTL and testbench

Parametrised program-counter generator for the fetch stage; successor to the single-width PC register.
- Adds a fetch valid/ready handshake, a stall input and a four-level redirect priority (exception > branch > return > sequential).
- Adds an internal return-address stack (RAS) of configurable depth.
- Feeds instruction memory address/enable and supplies pc + INST_BYTES to the decode and link logic.

---
 rtl/pc_unit_pkg.sv | 20 ++
 rtl/pc_unit_ras.sv | 51 +++++
 rtl/pc_unit.sv | 96 +++++++++
 tb/tb_pc_unit.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/pc_unit_pkg.sv
// Shared constants and types for the fetch-stage program counter and its return-address stack.
package pc_unit_pkg;

    localparam int          ADDR_W_DEF    = 32;
    localparam logic        RST_ENABLE    = 1'b0;
    localparam logic        BRANCH_ACTIVE = 1'b1;
    localparam logic [31:0] RESET_VEC_DEF = 32'h0000_0000;
    localparam logic [31:0] EXC_VEC_DEF   = 32'h0000_0100;

    // Which source produces the next pc, listed in priority order.
    typedef enum logic [2:0] {
        SEL_EXC,
        SEL_BRANCH,
        SEL_RET,
        SEL_UNDERFLOW,
        SEL_SEQ,
        SEL_HOLD
    } next_sel_t;

endpackage

// File: rtl/pc_unit_ras.sv
// Circular return-address stack. A push on a full stack overwrites the oldest entry.
module pc_ras
    import pc_unit_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [ADDR_W-1:0]        push_data,
    output logic [ADDR_W-1:0]        top,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  ptr;
    logic [PTR_W-1:0]  ptr_top;

    // ptr is the next free slot; the top lives one below it and wraps with DEPTH a power of two.
    assign ptr_top = ptr - PTR_W'(1);
    assign top     = mem[ptr_top];
    assign empty   = (count == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            ptr   <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            ptr   <= '0;
            count <= '0;
        end else if (push && pop) begin
            mem[ptr_top] <= push_data;
        end else if (push) begin
            mem[ptr] <= push_data;
            ptr      <= ptr + PTR_W'(1);
            if (count != CNT_W'(DEPTH)) count <= count + CNT_W'(1);
        end else if (pop) begin
            ptr   <= ptr_top;
            count <= count - CNT_W'(1);
        end
    end

endmodule

// File: rtl/pc_unit.sv
// Fetch-stage program counter: valid/ready fetch handshake, prioritised redirects and a return-address stack.
module pc_unit
    import pc_unit_pkg::*;
#(
    parameter int               ADDR_W     = ADDR_W_DEF,
    parameter int               INST_BYTES = 4,
    parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(RESET_VEC_DEF),
    parameter logic [ADDR_W-1:0] EXC_VEC   = ADDR_W'(EXC_VEC_DEF),
    parameter int               RAS_DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              fetch_ready,
    input  logic              branch_en,
    input  logic [ADDR_W-1:0] branch,
    input  logic              exc_en,
    input  logic              call_en,
    input  logic              ret_en,
    output logic              ce,
    output logic              fetch_valid,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus_4,
    output logic              ras_empty,
    output logic              ras_underflow
);

    logic                       running;
    logic                       fire;
    next_sel_t                  sel;
    logic [ADDR_W-1:0]          next_pc;
    logic [ADDR_W-1:0]          ras_top;
    logic                       ras_is_empty;
    logic [$clog2(RAS_DEPTH):0] ras_count;
    logic                       ras_push;
    logic                       ras_pop;

    assign ce          = running;
    assign fetch_valid = running;
    assign pc_plus_4   = pc + ADDR_W'(INST_BYTES);
    assign ras_empty   = (ras_count == '0);
    assign fire        = running & fetch_ready & ~stall;

    always_comb begin
        sel = SEL_HOLD;
        if (exc_en)                            sel = SEL_EXC;
        else if (branch_en == BRANCH_ACTIVE)   sel = SEL_BRANCH;
        else if (fire && ret_en && !ras_is_empty) sel = SEL_RET;
        else if (fire && ret_en)               sel = SEL_UNDERFLOW;
        else if (fire)                         sel = SEL_SEQ;
    end

    always_comb begin
        next_pc = pc;
        case (sel)
            SEL_EXC:       next_pc = EXC_VEC;
            SEL_BRANCH:    next_pc = branch;
            SEL_RET:       next_pc = ras_top;
            SEL_UNDERFLOW: next_pc = pc_plus_4;
            SEL_SEQ:       next_pc = pc_plus_4;
            default:       next_pc = pc;
        endcase
    end

    // A call is a jump, so it may push alongside a branch but never alongside an exception.
    assign ras_push = fire & call_en & ~exc_en;
    assign ras_pop  = (sel == SEL_RET);

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            pc            <= RESET_VEC;
            running       <= 1'b0;
            ras_underflow <= 1'b0;
        end else begin
            pc            <= next_pc;
            running       <= 1'b1;
            ras_underflow <= (sel == SEL_UNDERFLOW);
        end
    end

    pc_ras #(
        .ADDR_W (ADDR_W),
        .DEPTH  (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .flush     (exc_en),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (pc_plus_4),
        .top       (ras_top),
        .empty     (ras_is_empty),
        .count     (ras_count)
    );

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: sequential fetch, stalls, redirects, RAS push/pop/overflow/underflow, async reset.
module tb_pc_unit;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        fetch_ready;
    logic        branch_en;
    logic [31:0] branch;
    logic        exc_en;
    logic        call_en;
    logic        ret_en;
    logic        ce;
    logic        fetch_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus_4;
    logic        ras_empty;
    logic        ras_underflow;

    int tests_run;
    int tests_failed;

    pc_unit dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .fetch_ready   (fetch_ready),
        .branch_en     (branch_en),
        .branch        (branch),
        .exc_en        (exc_en),
        .call_en       (call_en),
        .ret_en        (ret_en),
        .ce            (ce),
        .fetch_valid   (fetch_valid),
        .pc            (pc),
        .pc_plus_4     (pc_plus_4),
        .ras_empty     (ras_empty),
        .ras_underflow (ras_underflow)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // checking
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // drivers
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stall     = 1'b0;
        branch_en = 1'b0;
        branch    = 32'h0;
        exc_en    = 1'b0;
        call_en   = 1'b0;
        ret_en    = 1'b0;
    endtask

    // one fetch that is a call and jumps to tgt
    task automatic call_jump(input logic [31:0] tgt);
        call_en = 1'b1; branch_en = 1'b1; branch = tgt;
        step();
        call_en = 1'b0; branch_en = 1'b0;
    endtask

    task automatic do_ret(input string tag, input logic [31:0] exp_pc);
        ret_en = 1'b1;
        step();
        ret_en = 1'b0;
        check(tag, pc, exp_pc);
    endtask

    initial begin
        logic [31:0] exp_ret [5];
        tests_run = 0;
        tests_failed = 0;
        idle_inputs();
        fetch_ready = 1'b0;
        rst = 1'b0;
        #12;
        check("rst_pc", pc, 32'h0);
        check("rst_ce", {31'b0, ce}, 32'h0);
        check("rst_valid", {31'b0, fetch_valid}, 32'h0);
        check("rst_ras_empty", {31'b0, ras_empty}, 32'h1);
        check("rst_underflow", {31'b0, ras_underflow}, 32'h0);
        check("rst_pc_plus_4", pc_plus_4, 32'h4);

        // release and run sequentially
        @(negedge clk);
        rst = 1'b1;
        fetch_ready = 1'b1;
        step();
        check("seq0_pc", pc, 32'h0);
        check("seq0_ce", {31'b0, ce}, 32'h1);
        check("seq0_valid", {31'b0, fetch_valid}, 32'h1);
        step(); check("seq1_pc", pc, 32'h4);
        step(); check("seq2_pc", pc, 32'h8);

        // not ready, then branch under stall
        fetch_ready = 1'b0;
        step(); check("nrdy0_pc", pc, 32'h8);
        check("nrdy0_valid", {31'b0, fetch_valid}, 32'h1);
        step(); check("nrdy1_pc", pc, 32'h8);
        fetch_ready = 1'b1; stall = 1'b1;
        step(); check("stall_pc", pc, 32'h8);
        branch_en = 1'b1; branch = 32'h40;
        step(); check("stall_branch_pc", pc, 32'h40);
        idle_inputs();

        // three nested calls and returns
        branch_en = 1'b1; branch = 32'h10;
        step(); branch_en = 1'b0;
        check("goto_10", pc, 32'h10);
        call_jump(32'h20);
        call_jump(32'h30);
        call_jump(32'h80);
        check("call3_pc", pc, 32'h80);
        check("call3_not_empty", {31'b0, ras_empty}, 32'h0);
        do_ret("ret1", 32'h34);
        do_ret("ret2", 32'h24);
        do_ret("ret3", 32'h14);
        check("ret3_empty", {31'b0, ras_empty}, 32'h1);

        // overflow: five calls into a four-deep stack
        call_jump(32'h200);
        call_jump(32'h300);
        call_jump(32'h400);
        call_jump(32'h500);
        call_jump(32'h600);
        exp_ret[0] = 32'h504; exp_ret[1] = 32'h404; exp_ret[2] = 32'h304; exp_ret[3] = 32'h204;
        for (int i = 0; i < 4; i++) begin
            do_ret($sformatf("ovf_ret%0d", i), exp_ret[i]);
            check($sformatf("ovf_ret%0d_uf", i), {31'b0, ras_underflow}, 32'h0);
        end
        check("ovf_empty", {31'b0, ras_empty}, 32'h1);
        do_ret("underflow_pc", 32'h208);
        check("underflow_pulse", {31'b0, ras_underflow}, 32'h1);
        step();
        check("underflow_clear", {31'b0, ras_underflow}, 32'h0);
        check("after_uf_pc", pc, 32'h20c);

        // simultaneous call and return replaces the top
        call_jump(32'h1000);
        call_jump(32'h2000);
        call_en = 1'b1; ret_en = 1'b1;
        step();
        call_en = 1'b0; ret_en = 1'b0;
        check("callret_pc", pc, 32'h1004);
        do_ret("callret_top", 32'h2004);
        check("callret_not_empty", {31'b0, ras_empty}, 32'h0);
        call_jump(32'h3000);

        // exception beats branch and flushes the stack
        exc_en = 1'b1; branch_en = 1'b1; branch = 32'h4000;
        step();
        idle_inputs();
        check("exc_pc", pc, 32'h100);
        check("exc_empty", {31'b0, ras_empty}, 32'h1);

        // asynchronous reset mid-cycle
        branch_en = 1'b1; branch = 32'h40;
        step();
        idle_inputs();
        check("pre_rst_pc", pc, 32'h40);
        #2 rst = 1'b0;
        #1;
        check("async_rst_pc", pc, 32'h0);
        check("async_rst_ce", {31'b0, ce}, 32'h0);
        check("async_rst_valid", {31'b0, fetch_valid}, 32'h0);

        // pc_plus_4 wraps at the top of the address space
        @(negedge clk);
        rst = 1'b1;
        branch_en = 1'b1; branch = 32'hFFFF_FFFC;
        step();
        branch_en = 1'b0;
        check("wrap_pc", pc, 32'hFFFF_FFFC);
        check("wrap_pc_plus_4", pc_plus_4, 32'h0);
        step();
        check("wrap_seq_pc", pc, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
